// File: rtl/turn_timer_multi_pkg.sv
// Shared types and helpers for the N-player turn timer.
package turn_timer_pkg;

  // Top-level control state of the turn timer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } tt_state_t;

  // Index of the player after `cur` in a rotation of `n` players.
  // Explicit wrap, so player counts that are not a power of two rotate correctly.
  function automatic int unsigned next_player(input int unsigned cur,
                                              input int unsigned n);
    return (cur >= n - 1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/turn_timer_multi_tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_FREQ enabled cycles.
// The count holds while en is low, so a paused turn keeps its sub-second phase.
// clr takes priority over en.
module tick_prescaler #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

  logic [CW-1:0] r_count;

  // The tick fires on the last phase of an enabled second.
  assign tick = en && (r_count == LAST);

  // Phase counter: clear, hold, or advance with wrap at the end of a second.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      if (r_count == LAST) r_count <= '0;
      else                 r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/turn_timer_multi.sv
// N-player turn timer: counts down a per-turn budget, rotates the active player
// on move completion or expiry, supports pause without losing the sub-second
// phase, and raises a warning flag and a one-cycle timeout strobe.
module turn_timer_multi
  import turn_timer_pkg::*;
#(
  parameter  int CLK_FREQ     = 50_000_000,
  parameter  int NUM_PLAYERS  = 2,
  parameter  int TURN_SECONDS = 10,
  parameter  int WARN_SECONDS = 3,
  localparam int PW           = $clog2(NUM_PLAYERS),
  localparam int SW           = $clog2(TURN_SECONDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          move_done,
  input  logic          pause,
  input  logic          abort,
  output logic [PW-1:0] active_player,
  output logic [SW-1:0] seconds_left,
  output logic          running,
  output logic          paused,
  output logic          warning,
  output logic          timeout_pulse,
  output logic [PW-1:0] timeout_player
);

  localparam logic [SW-1:0] SEC_FULL = SW'(TURN_SECONDS);
  localparam logic [SW-1:0] SEC_WARN = SW'(WARN_SECONDS);
  localparam logic [SW-1:0] SEC_ONE  = SW'(1);

  tt_state_t     r_state;
  tt_state_t     w_state_next;
  logic [PW-1:0] r_player;
  logic [SW-1:0] r_seconds;
  logic          r_timeout_pulse;
  logic [PW-1:0] r_timeout_player;

  logic          w_in_play;
  logic          w_start_ev;
  logic          w_abort_ev;
  logic          w_move_ev;
  logic          w_presc_en;
  logic          w_presc_clr;
  logic          w_tick;
  logic          w_expiry;
  logic          w_decrement;
  logic [PW-1:0] w_player_next;

  // Event decode, encoding abort > move_done > expiry tick > pause.
  assign w_in_play   = (r_state != IDLE);
  assign w_start_ev  = (r_state == IDLE) && start;
  assign w_abort_ev  = w_in_play && abort;
  assign w_move_ev   = w_in_play && move_done && !abort;

  // The prescaler only advances in RUN with pause low, so the edge that enters
  // PAUSED consumes no phase. Any turn restart realigns it to a fresh second.
  assign w_presc_en  = (r_state == RUN) && !pause;
  assign w_presc_clr = w_start_ev || w_abort_ev || w_move_ev;

  assign w_expiry    = w_tick && (r_seconds == SEC_ONE) && !w_abort_ev && !w_move_ev;
  assign w_decrement = w_tick && (r_seconds >  SEC_ONE) && !w_abort_ev && !w_move_ev;

  assign w_player_next = PW'(next_player(32'(r_player), NUM_PLAYERS));

  tick_prescaler #(
    .CLK_FREQ(CLK_FREQ)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_presc_en),
    .clr  (w_presc_clr),
    .tick (w_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; move_done never changes state on its own.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        if (abort)      w_state_next = IDLE;
        else if (pause) w_state_next = PAUSED;
      end
      PAUSED: begin
        if (abort)       w_state_next = IDLE;
        else if (!pause) w_state_next = RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Seconds counter and active player: load on start, clear on abort,
  // advance-and-reload on move_done or expiry, count down on a plain tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_player  <= '0;
      r_seconds <= '0;
    end else if (w_start_ev) begin
      r_player  <= '0;
      r_seconds <= SEC_FULL;
    end else if (w_abort_ev) begin
      r_player  <= '0;
      r_seconds <= '0;
    end else if (w_move_ev || w_expiry) begin
      r_player  <= w_player_next;
      r_seconds <= SEC_FULL;
    end else if (w_decrement) begin
      r_seconds <= r_seconds - 1'b1;
    end
  end

  // Timeout strobe: one cycle wide, tagged with the player whose turn ran out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout_pulse  <= 1'b0;
      r_timeout_player <= '0;
    end else begin
      r_timeout_pulse <= w_expiry;
      if (w_expiry) r_timeout_player <= r_player;
    end
  end

  // Outputs come straight from registers or simple decodes of them.
  assign active_player  = r_player;
  assign seconds_left   = r_seconds;
  assign running        = w_in_play;
  assign paused         = (r_state == PAUSED);
  assign warning        = w_in_play && (r_seconds <= SEC_WARN);
  assign timeout_pulse  = r_timeout_pulse;
  assign timeout_player = r_timeout_player;

endmodule
